// File: rtl/pong_engine.sv
// Single-clock Pong game engine: frame-rate game logic advanced on vsync rising
// edges, plus a zero-latency pixel renderer for paddles, ball and centre net.
module pong_engine #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int PADDLE_H     = 64,
  parameter int PADDLE_W     = 8,
  parameter int BALL_SIZE    = 8,
  parameter int PADDLE_SPEED = 4,
  parameter int BALL_SPEED   = 4,
  parameter int SCORE_W      = 8,
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vsync,
  input  logic [9:0]         pix_x,
  input  logic [9:0]         pix_y,
  input  logic [3:0]         btn,
  input  logic               mode,
  input  logic               start,
  output logic               draw,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SERVE    = 2'd1,
    PLAY     = 2'd2,
    GAMEOVER = 2'd3
  } state_t;

  localparam logic [9:0]         CX         = 10'(H_ACTIVE / 2);
  localparam logic [9:0]         CY         = 10'(V_ACTIVE / 2);
  localparam logic [9:0]         PAD_MID    = 10'((V_ACTIVE - PADDLE_H) / 2);
  localparam logic [9:0]         PAD_W10    = 10'(PADDLE_W);
  localparam logic [9:0]         RIGHT_X10  = 10'(H_ACTIVE - PADDLE_W - BALL_SIZE);
  localparam logic [9:0]         BALL_MAX10 = 10'(V_ACTIVE - BALL_SIZE);
  localparam logic signed [11:0] S_BALL_SPD = 12'(BALL_SPEED);
  localparam logic signed [11:0] S_PAD_SPD  = 12'(PADDLE_SPEED);
  localparam logic signed [11:0] S_PAD_W    = 12'(PADDLE_W);
  localparam logic signed [11:0] S_PAD_H    = 12'(PADDLE_H);
  localparam logic signed [11:0] S_BALL     = 12'(BALL_SIZE);
  localparam logic signed [11:0] S_PAD_MAX  = 12'(V_ACTIVE - PADDLE_H);
  localparam logic signed [11:0] S_BALL_MAX = 12'(V_ACTIVE - BALL_SIZE);
  localparam logic signed [11:0] S_RIGHT_X  = 12'(H_ACTIVE - PADDLE_W - BALL_SIZE);
  localparam logic [15:0]        SERVE_LOAD = 16'(SERVE_FRAMES);
  localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);

  state_t             st_q, st_d;
  logic [9:0]         bx_q, bx_d, by_q, by_d;
  logic [9:0]         pl_q, pl_d, pr_q, pr_d;
  logic               dx_q, dx_d, dy_q, dy_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [SCORE_W-1:0] sl_q, sl_d, sr_q, sr_d;
  logic [SCORE_W-1:0] sl_inc, sr_inc;
  logic               vs_q;
  logic               frame_tick;
  logic               miss_l, miss_r;

  logic signed [11:0] bx_s, by_s, pl_s, pr_s, nx, ny, ball_c, pad_c;
  logic               ovl_l, ovl_r, ai_up, ai_dn, r_up, r_dn;

  assign frame_tick = vsync & ~vs_q;
  assign state      = st_q;
  assign score_l    = sl_q;
  assign score_r    = sr_q;
  assign sl_inc     = sl_q + SCORE_W'(1);
  assign sr_inc     = sr_q + SCORE_W'(1);

  // Position maths runs 12-bit signed so a step past 0 stays negative.
  assign bx_s = signed'({2'b00, bx_q});
  assign by_s = signed'({2'b00, by_q});
  assign pl_s = signed'({2'b00, pl_q});
  assign pr_s = signed'({2'b00, pr_q});
  assign nx   = dx_q ? bx_s + S_BALL_SPD : bx_s - S_BALL_SPD;
  assign ny   = dy_q ? by_s + S_BALL_SPD : by_s - S_BALL_SPD;

  assign ovl_l = (by_s < pl_s + S_PAD_H) && (pl_s < by_s + S_BALL);
  assign ovl_r = (by_s < pr_s + S_PAD_H) && (pr_s < by_s + S_BALL);

  // Automatic right paddle chases the ball centre with a dead band of one step.
  assign ball_c = by_s + (S_BALL >>> 1);
  assign pad_c  = pr_s + (S_PAD_H >>> 1);
  assign ai_up  = pad_c > ball_c + S_PAD_SPD;
  assign ai_dn  = ball_c > pad_c + S_PAD_SPD;
  assign r_up   = mode ? ai_up : btn[2];
  assign r_dn   = mode ? ai_dn : btn[3];

  function automatic logic [9:0] move_pad(input logic [9:0] y, input logic up, input logic dn);
    logic signed [11:0] t;
    t = signed'({2'b00, y});
    if (up && !dn) begin
      t = t - S_PAD_SPD;
      if (t < 12'sd0) t = 12'sd0;
    end else if (dn && !up) begin
      t = t + S_PAD_SPD;
      if (t > S_PAD_MAX) t = S_PAD_MAX;
    end
    return t[9:0];
  endfunction

  always_comb begin
    st_d   = st_q;
    bx_d   = bx_q;
    by_d   = by_q;
    pl_d   = pl_q;
    pr_d   = pr_q;
    dx_d   = dx_q;
    dy_d   = dy_q;
    cnt_d  = cnt_q;
    sl_d   = sl_q;
    sr_d   = sr_q;
    miss_l = 1'b0;
    miss_r = 1'b0;
    case (st_q)
      IDLE, GAMEOVER: begin
        if (start) begin
          st_d  = SERVE;
          sl_d  = '0;
          sr_d  = '0;
          bx_d  = CX;
          by_d  = CY;
          dx_d  = 1'b1;
          dy_d  = 1'b1;
          pl_d  = PAD_MID;
          pr_d  = PAD_MID;
          cnt_d = SERVE_LOAD;
        end
      end
      SERVE: begin
        if (frame_tick) begin
          pl_d = move_pad(pl_q, btn[0], btn[1]);
          pr_d = move_pad(pr_q, r_up, r_dn);
          bx_d = CX;
          by_d = CY;
          if (cnt_q == '0) st_d = PLAY;
          else cnt_d = cnt_q - 16'd1;
        end
      end
      PLAY: begin
        if (frame_tick) begin
          pl_d = move_pad(pl_q, btn[0], btn[1]);
          pr_d = move_pad(pr_q, r_up, r_dn);
          if (ny <= 12'sd0) begin
            by_d = '0;
            dy_d = 1'b1;
          end else if (ny >= S_BALL_MAX) begin
            by_d = BALL_MAX10;
            dy_d = 1'b0;
          end else begin
            by_d = ny[9:0];
          end
          bx_d = nx[9:0];
          if (!dx_q && nx <= S_PAD_W) begin
            if (ovl_l) begin
              bx_d = PAD_W10;
              dx_d = 1'b1;
            end else begin
              miss_l = 1'b1;
            end
          end else if (dx_q && nx >= S_RIGHT_X) begin
            if (ovl_r) begin
              bx_d = RIGHT_X10;
              dx_d = 1'b0;
            end else begin
              miss_r = 1'b1;
            end
          end
          if (miss_l || miss_r) begin
            if (miss_l) sr_d = sr_inc;
            else sl_d = sl_inc;
            if ((miss_l && sr_inc == WIN) || (miss_r && sl_inc == WIN)) begin
              // Winning point: the ball stays where it was on the scoring tick.
              st_d = GAMEOVER;
              bx_d = bx_q;
              by_d = by_q;
              dx_d = dx_q;
              dy_d = dy_q;
            end else begin
              // Next serve travels toward the player who just lost the point.
              st_d  = SERVE;
              cnt_d = SERVE_LOAD;
              bx_d  = CX;
              by_d  = CY;
              dx_d  = miss_r;
              dy_d  = 1'b1;
            end
          end
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q  <= IDLE;
      bx_q  <= CX;
      by_q  <= CY;
      dx_q  <= 1'b1;
      dy_q  <= 1'b1;
      pl_q  <= PAD_MID;
      pr_q  <= PAD_MID;
      cnt_q <= '0;
      sl_q  <= '0;
      sr_q  <= '0;
      vs_q  <= 1'b1;
    end else begin
      st_q  <= st_d;
      bx_q  <= bx_d;
      by_q  <= by_d;
      dx_q  <= dx_d;
      dy_q  <= dy_d;
      pl_q  <= pl_d;
      pr_q  <= pr_d;
      cnt_q <= cnt_d;
      sl_q  <= sl_d;
      sr_q  <= sr_d;
      vs_q  <= vsync;
    end
  end

  logic [10:0] px, py;
  logic        on_l, on_r, on_b, on_net;

  assign px     = {1'b0, pix_x};
  assign py     = {1'b0, pix_y};
  assign on_l   = (px < 11'(PADDLE_W)) &&
                  (py >= {1'b0, pl_q}) && (py < {1'b0, pl_q} + 11'(PADDLE_H));
  assign on_r   = (px >= 11'(H_ACTIVE - PADDLE_W)) && (px < 11'(H_ACTIVE)) &&
                  (py >= {1'b0, pr_q}) && (py < {1'b0, pr_q} + 11'(PADDLE_H));
  assign on_b   = (px >= {1'b0, bx_q}) && (px < {1'b0, bx_q} + 11'(BALL_SIZE)) &&
                  (py >= {1'b0, by_q}) && (py < {1'b0, by_q} + 11'(BALL_SIZE));
  assign on_net = ((px == 11'(H_ACTIVE / 2 - 1)) || (px == 11'(H_ACTIVE / 2))) && !pix_y[3];
  assign draw   = on_l | on_r | on_b | on_net;

endmodule

// File: tb/tb_pong_engine.sv
// Directed bench for pong_engine at default parameters; every expected value
// below is a hand-traced ball/paddle position, score or state.
module tb_pong_engine;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vsync = 1'b0;
  logic       mode = 1'b0;
  logic       start = 1'b0;
  logic [9:0] pix_x = '0;
  logic [9:0] pix_y = '0;
  logic [3:0] btn = '0;
  logic       draw;
  logic [7:0] score_l, score_r;
  logic [1:0] state;
  int         n_cmp = 0;
  int         n_bad = 0;

  pong_engine dut (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .pix_x(pix_x), .pix_y(pix_y),
    .btn(btn), .mode(mode), .start(start), .draw(draw),
    .score_l(score_l), .score_r(score_r), .state(state)
  );

  always #5 clk = ~clk;

  // ---- drivers (all return at a falling edge) ----
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; btn = '0; mode = 1'b0; vsync = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      vsync = 1'b0;
      @(negedge clk);
      vsync = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Reset, start, then serve for 61 frames with optional paddle positioning.
  task automatic start_game(input int r_down_ticks, input logic l_up);
    do_reset();
    pulse_start();
    for (int i = 0; i < 61; i++) begin
      btn = {(i < r_down_ticks), 1'b0, 1'b0, l_up};
      tick(1);
    end
    btn = '0;
  endtask

  task automatic probe(input int x, input int y);
    pix_x = 10'(x);
    pix_y = 10'(y);
    #1;
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    do_reset();
    n_cmp++; if (state !== 2'd0) begin $display("FAIL reset_state got %0d want 0", state); n_bad++; end
    n_cmp++; if (score_l !== 8'd0) begin $display("FAIL reset_score_l got %0d want 0", score_l); n_bad++; end
    n_cmp++; if (score_r !== 8'd0) begin $display("FAIL reset_score_r got %0d want 0", score_r); n_bad++; end
    probe(323, 244);
    n_cmp++; if (draw !== 1'b1) begin $display("FAIL reset_ball_centre got %b want 1", draw); n_bad++; end
    probe(3, 208);
    n_cmp++; if (draw !== 1'b1) begin $display("FAIL reset_padl_top got %b want 1", draw); n_bad++; end
    probe(3, 207);
    n_cmp++; if (draw !== 1'b0) begin $display("FAIL reset_padl_above got %b want 0", draw); n_bad++; end
    probe(635, 271);
    n_cmp++; if (draw !== 1'b1) begin $display("FAIL reset_padr_bottom got %b want 1", draw); n_bad++; end
    probe(635, 272);
    n_cmp++; if (draw !== 1'b0) begin $display("FAIL reset_padr_below got %b want 0", draw); n_bad++; end
    btn = 4'b0001;
    tick(3);
    btn = '0;
    n_cmp++; if (state !== 2'd0) begin $display("FAIL idle_hold_state got %0d want 0", state); n_bad++; end
    probe(3, 207);
    n_cmp++; if (draw !== 1'b0) begin $display("FAIL idle_padl_frozen got %b want 0", draw); n_bad++; end
  endtask

  task automatic test_net();
    probe(320, 5);
    n_cmp++; if (draw !== 1'b1) begin $display("FAIL net_320_5 got %b want 1", draw); n_bad++; end
    probe(319, 16);
    n_cmp++; if (draw !== 1'b1) begin $display("FAIL net_319_16 got %b want 1", draw); n_bad++; end
    probe(320, 8);
    n_cmp++; if (draw !== 1'b0) begin $display("FAIL net_gap_320_8 got %b want 0", draw); n_bad++; end
    probe(321, 5);
    n_cmp++; if (draw !== 1'b0) begin $display("FAIL net_off_321_5 got %b want 0", draw); n_bad++; end
  endtask

  task automatic test_serve();
    do_reset();
    pulse_start();
    n_cmp++; if (state !== 2'd1) begin $display("FAIL start_state got %0d want 1", state); n_bad++; end
    n_cmp++; if (score_l !== 8'd0 || score_r !== 8'd0) begin
      $display("FAIL start_scores got %0d/%0d want 0/0", score_l, score_r); n_bad++; end
    tick(60);
    n_cmp++; if (state !== 2'd1) begin $display("FAIL serve_60 got %0d want 1", state); n_bad++; end
    tick(1);
    n_cmp++; if (state !== 2'd2) begin $display("FAIL serve_61 got %0d want 2", state); n_bad++; end
  endtask

  task automatic test_paddle();
    btn = 4'b0011;
    tick(10);
    probe(3, 208);
    n_cmp++; if (draw !== 1'b1) begin $display("FAIL both_btn_top got %b want 1", draw); n_bad++; end
    probe(3, 207);
    n_cmp++; if (draw !== 1'b0) begin $display("FAIL both_btn_above got %b want 0", draw); n_bad++; end
    btn = 4'b0001;
    tick(200);
    probe(3, 0);
    n_cmp++; if (draw !== 1'b1) begin $display("FAIL up_clamp_top got %b want 1", draw); n_bad++; end
    probe(3, 64);
    n_cmp++; if (draw !== 1'b0) begin $display("FAIL up_clamp_below got %b want 0", draw); n_bad++; end
    tick(5);
    probe(3, 63);
    n_cmp++; if (draw !== 1'b1) begin $display("FAIL up_stays_63 got %b want 1", draw); n_bad++; end
    btn = 4'b0010;
    tick(120);
    btn = '0;
    probe(3, 479);
    n_cmp++; if (draw !== 1'b1) begin $display("FAIL dn_clamp_479 got %b want 1", draw); n_bad++; end
    probe(3, 415);
    n_cmp++; if (draw !== 1'b0) begin $display("FAIL dn_clamp_415 got %b want 0", draw); n_bad++; end
  endtask

  task automatic test_rally();
    start_game(34, 1'b0);
    n_cmp++; if (state !== 2'd2) begin $display("FAIL rally_play got %0d want 2", state); n_bad++; end
    tick(75);
    probe(620, 404);
    n_cmp++; if (draw !== 1'b1) begin $display("FAIL rally_pre_hit got %b want 1", draw); n_bad++; end
    probe(619, 404);
    n_cmp++; if (draw !== 1'b0) begin $display("FAIL rally_pre_hit_edge got %b want 0", draw); n_bad++; end
    tick(1);
    probe(624, 400);
    n_cmp++; if (draw !== 1'b1) begin $display("FAIL right_hit_pos got %b want 1", draw); n_bad++; end
    probe(624, 399);
    n_cmp++; if (draw !== 1'b0) begin $display("FAIL right_hit_edge got %b want 0", draw); n_bad++; end
    n_cmp++; if (score_l !== 8'd0 || state !== 2'd2) begin
      $display("FAIL right_hit_no_point got score %0d state %0d want 0 2", score_l, state); n_bad++; end
    tick(99);
    probe(228, 4);
    n_cmp++; if (draw !== 1'b1) begin $display("FAIL wall_pre got %b want 1", draw); n_bad++; end
    probe(228, 3);
    n_cmp++; if (draw !== 1'b0) begin $display("FAIL wall_pre_edge got %b want 0", draw); n_bad++; end
    tick(1);
    probe(224, 0);
    n_cmp++; if (draw !== 1'b1) begin $display("FAIL wall_clamp got %b want 1", draw); n_bad++; end
    probe(223, 0);
    n_cmp++; if (draw !== 1'b0) begin $display("FAIL wall_clamp_edge got %b want 0", draw); n_bad++; end
    tick(1);
    probe(220, 4);
    n_cmp++; if (draw !== 1'b1) begin $display("FAIL wall_dy_pos got %b want 1", draw); n_bad++; end
    probe(220, 3);
    n_cmp++; if (draw !== 1'b0) begin $display("FAIL wall_dy_pos_edge got %b want 0", draw); n_bad++; end
    tick(52);
    probe(12, 212);
    n_cmp++; if (draw !== 1'b1) begin $display("FAIL left_pre_hit got %b want 1", draw); n_bad++; end
    tick(1);
    probe(8, 216);
    n_cmp++; if (draw !== 1'b1) begin $display("FAIL left_hit_pos got %b want 1", draw); n_bad++; end
    probe(16, 216);
    n_cmp++; if (draw !== 1'b0) begin $display("FAIL left_hit_edge got %b want 0", draw); n_bad++; end
    n_cmp++; if (score_r !== 8'd0) begin $display("FAIL left_hit_no_point got %0d want 0", score_r); n_bad++; end
    tick(1);
    probe(12, 220);
    n_cmp++; if (draw !== 1'b1) begin $display("FAIL left_hit_dx_pos got %b want 1", draw); n_bad++; end
    probe(11, 220);
    n_cmp++; if (draw !== 1'b0) begin $display("FAIL left_hit_dx_edge got %b want 0", draw); n_bad++; end
  endtask

  task automatic test_left_miss();
    start_game(34, 1'b1);
    tick(230);
    n_cmp++; if (score_r !== 8'd1) begin $display("FAIL lmiss_score_r got %0d want 1", score_r); n_bad++; end
    n_cmp++; if (score_l !== 8'd0) begin $display("FAIL lmiss_score_l got %0d want 0", score_l); n_bad++; end
    n_cmp++; if (state !== 2'd1) begin $display("FAIL lmiss_state got %0d want 1", state); n_bad++; end
    probe(323, 244);
    n_cmp++; if (draw !== 1'b1) begin $display("FAIL lmiss_centred got %b want 1", draw); n_bad++; end
    tick(60);
    n_cmp++; if (state !== 2'd1) begin $display("FAIL lmiss_reserve_60 got %0d want 1", state); n_bad++; end
    tick(1);
    n_cmp++; if (state !== 2'd2) begin $display("FAIL lmiss_reserve_61 got %0d want 2", state); n_bad++; end
    tick(1);
    probe(316, 244);
    n_cmp++; if (draw !== 1'b1) begin $display("FAIL lmiss_serve_dx_neg got %b want 1", draw); n_bad++; end
    probe(315, 244);
    n_cmp++; if (draw !== 1'b0) begin $display("FAIL lmiss_serve_edge got %b want 0", draw); n_bad++; end
    probe(316, 243);
    n_cmp++; if (draw !== 1'b0) begin $display("FAIL lmiss_serve_dy_pos got %b want 0", draw); n_bad++; end
  endtask

  task automatic test_gameover();
    start_game(0, 1'b0);
    tick(1035);
    n_cmp++; if (score_l !== 8'd8 || state !== 2'd1) begin
      $display("FAIL go_eight got score %0d state %0d want 8 1", score_l, state); n_bad++; end
    tick(137);
    n_cmp++; if (score_l !== 8'd9) begin $display("FAIL go_score got %0d want 9", score_l); n_bad++; end
    n_cmp++; if (state !== 2'd3) begin $display("FAIL go_state got %0d want 3", state); n_bad++; end
    probe(620, 404);
    n_cmp++; if (draw !== 1'b1) begin $display("FAIL go_ball_frozen got %b want 1", draw); n_bad++; end
    probe(323, 244);
    n_cmp++; if (draw !== 1'b0) begin $display("FAIL go_not_centred got %b want 0", draw); n_bad++; end
    btn = 4'b0001;
    tick(10);
    btn = '0;
    n_cmp++; if (state !== 2'd3 || score_l !== 8'd9 || score_r !== 8'd0) begin
      $display("FAIL go_hold got state %0d scores %0d/%0d want 3 9/0", state, score_l, score_r); n_bad++; end
    probe(620, 404);
    n_cmp++; if (draw !== 1'b1) begin $display("FAIL go_ball_hold got %b want 1", draw); n_bad++; end
    probe(3, 207);
    n_cmp++; if (draw !== 1'b0) begin $display("FAIL go_padl_hold got %b want 0", draw); n_bad++; end
    pulse_start();
    n_cmp++; if (state !== 2'd1 || score_l !== 8'd0 || score_r !== 8'd0) begin
      $display("FAIL go_restart got state %0d scores %0d/%0d want 1 0/0", state, score_l, score_r); n_bad++; end
    probe(323, 244);
    n_cmp++; if (draw !== 1'b1) begin $display("FAIL go_restart_centre got %b want 1", draw); n_bad++; end
  endtask

  task automatic test_auto();
    do_reset();
    mode = 1'b1;
    pulse_start();
    btn = 4'b1000;
    tick(61);
    n_cmp++; if (state !== 2'd2) begin $display("FAIL auto_play got %0d want 2", state); n_bad++; end
    probe(635, 208);
    n_cmp++; if (draw !== 1'b1) begin $display("FAIL auto_serve_top got %b want 1", draw); n_bad++; end
    probe(635, 207);
    n_cmp++; if (draw !== 1'b0) begin $display("FAIL auto_btn_ignored got %b want 0", draw); n_bad++; end
    btn = 4'b0100;
    tick(10);
    btn = '0;
    probe(635, 244);
    n_cmp++; if (draw !== 1'b1) begin $display("FAIL auto_track_top got %b want 1", draw); n_bad++; end
    probe(635, 243);
    n_cmp++; if (draw !== 1'b0) begin $display("FAIL auto_track_above got %b want 0", draw); n_bad++; end
    mode = 1'b0;
  endtask

  task automatic test_reset_override();
    start_game(0, 1'b0);
    tick(5);
    vsync = 1'b0;
    @(negedge clk);
    rst_n = 1'b0; start = 1'b1; vsync = 1'b1;
    @(negedge clk);
    n_cmp++; if (state !== 2'd0) begin $display("FAIL rst_override_state got %0d want 0", state); n_bad++; end
    probe(323, 244);
    n_cmp++; if (draw !== 1'b1) begin $display("FAIL rst_override_ball got %b want 1", draw); n_bad++; end
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if (state !== 2'd1) begin $display("FAIL rst_release_start got %0d want 1", state); n_bad++; end
  endtask

  initial begin
    test_reset();
    test_net();
    test_serve();
    test_paddle();
    test_rally();
    test_left_miss();
    test_gameover();
    test_auto();
    test_reset_override();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pong_engine.md
PONG_ENGINE -- requirements
Module: pong_engine

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible width in pixels.
REQ-002 SHALL have parameter V_ACTIVE, default 480, visible height in pixels.
REQ-003 SHALL have parameter PADDLE_H, default 64, paddle height; PADDLE_W, default 8, paddle width.
REQ-004 SHALL have parameter BALL_SIZE, default 8, square ball edge length.
REQ-005 SHALL have parameter PADDLE_SPEED, default 4, and BALL_SPEED, default 4, both in pixels per frame.
REQ-006 SHALL have parameter SCORE_W, default 8, score width, and WIN_SCORE, default 9, winning score.
REQ-007 SHALL have parameter SERVE_FRAMES, default 60, serve delay in frames.
REQ-008 SHALL have port clk, input, 1, the single clock.
REQ-009 SHALL have port rst_n, input, 1, reset: synchronous and active-low.
REQ-010 SHALL have port vsync, input, 1, vertical sync from the sync generator.
REQ-011 SHALL have ports pix_x and pix_y, input, 10 each, current pixel coordinates.
REQ-012 SHALL have port btn, input, 4: [0] L up, [1] L down, [2] R up, [3] R down.
REQ-013 SHALL have port mode, input, 1: 0 two-player, 1 right paddle automatic.
REQ-014 SHALL have port start, input, 1, level-sampled start request.
REQ-015 SHALL have port draw, output, 1, high when the current pixel is lit.
REQ-016 SHALL have ports score_l and score_r, output, SCORE_W each.
REQ-017 SHALL have port state, output, 2: IDLE=0, SERVE=1, PLAY=2, GAMEOVER=3.

Function
REQ-018 frame_tick SHALL be a one-cycle pulse when vsync is sampled high and was sampled low on the previous cycle; all game updates SHALL occur only on frame_tick, except start handling.
REQ-019 In IDLE or GAMEOVER, start=1 SHALL on the next clock clear both scores, centre the ball and paddles, load the serve counter with SERVE_FRAMES, and enter SERVE, with or without frame_tick.
REQ-020 In SERVE, the ball SHALL stay at the centre (H_ACTIVE/2, V_ACTIVE/2). The counter SHALL decrement per frame_tick. On the tick where it is 0, state SHALL become PLAY.
REQ-021 Paddles SHALL move in SERVE and PLAY only, by PADDLE_SPEED per tick, with y clamped to [0, V_ACTIVE-PADDLE_H]. Up and down both pressed, or neither pressed, SHALL mean no move.
REQ-022 When mode=1, the right paddle SHALL ignore btn[3:2]. Each tick it SHALL move PADDLE_SPEED toward the ball centre, with no move if within PADDLE_SPEED of aligned, and the same clamp applies.
REQ-023 In PLAY, per tick the ball SHALL move by ±BALL_SPEED in x and in y. Intermediate position maths SHALL use at least 11-bit signed width so no underflow wraps.
REQ-024 A ball next-y <=0 or >= V_ACTIVE-BALL_SIZE SHALL be clamped to that bound and its dy negated in the same tick.
REQ-025 Moving left with next-x <= PADDLE_W: if [ball_y, ball_y+BALL_SIZE) overlaps [padL_y, padL_y+PADDLE_H), x SHALL be set to PADDLE_W and dx SHALL become +.
REQ-026 Moving left with next-x <= PADDLE_W and no overlap SHALL be a point: score_r+1.
REQ-027 The right side SHALL mirror REQ-025/026 at x = H_ACTIVE-PADDLE_W-BALL_SIZE. A miss there SHALL give score_l+1.
REQ-028 After a point, if the incremented score equals WIN_SCORE, state SHALL become GAMEOVER with the ball frozen. Otherwise state SHALL become SERVE with the counter reloaded, and the next serve SHALL head toward the player who lost the point (dx sign) with dy = +.
REQ-029 Scores SHALL never exceed WIN_SCORE and SHALL hold in GAMEOVER until start.
REQ-030 draw SHALL be combinational from pix_x/pix_y and the registered positions, with zero latency. It SHALL be the OR of: left paddle rectangle, right paddle rectangle, ball square (all states), and centre net (pix_x in {H_ACTIVE/2-1, H_ACTIVE/2} and pix_y[3]==0).
REQ-031 Inputs btn and mode SHALL be sampled only on frame_tick; changes mid-frame SHALL have no effect until the next tick.

Reset
REQ-032 rst_n=0 at a clock edge SHALL set state IDLE, score_l=score_r=0, and ball at the centre with dx=+, dy=+.
REQ-033 Reset SHALL also set both paddles to y=(V_ACTIVE-PADDLE_H)/2, the serve counter to 0, and the vsync history to 1, so there is no spurious tick.
REQ-034 Reset SHALL override every other input, including start and frame_tick arriving in the same cycle, and mid-PLAY.

Verification
REQ-035 Reset, then start=1 for 1 cycle -> state=1, scores 0. After 61 vsync rising edges -> state=2.
REQ-036 In PLAY, hold btn[0] for 200 frames -> left paddle y=0 and stays 0. btn[0] and btn[1] held together -> y unchanged.
REQ-037 Park the left paddle at y=0 with the ball heading left at y=300 -> on the miss tick score_r=1, state=1, ball centred, next serve dx=-.
REQ-038 Ball at y=4 moving up -> next tick y=0, dy=+. Ball at paddle overlap -> x=PADDLE_W, dx=+, score unchanged.
REQ-039 With score_l=8, a right miss -> score_l=9, state=3. Further ticks change nothing. start -> state=1, scores 0.
REQ-040 pix_x=320, pix_y=5 -> draw=1. pix_y=8 -> draw=0 with no other object there. mode=1 -> right paddle tracks the ball with btn[3:2] ignored.
